// File: rtl/osiris_lsu_pkg.sv
// Shared definitions for the OSIRIS I MEM-stage load/store unit:
// access-size encodings, FSM states, timeout counter width and store/alignment helpers.
package osiris_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int TIMEOUT_CNT_W      = $clog2(TIMEOUT_CYCLES_DEF);

    // Stores only support B/H/W; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        case (f3[1:0])
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wd;
        wd = data;
        case (f3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             o_dmem_req;
    logic             o_dmem_we;
    logic [WIDTH-1:0] o_dmem_addr;
    logic [3:0]       o_dmem_be;
    logic [WIDTH-1:0] o_dmem_wdata;
    logic             i_dmem_ack;
    logic [WIDTH-1:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: picks the byte/half at the access offset
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import osiris_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension.
    always_comb begin
        byte_s = rdata_i[7:0];
        half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (offset_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        case (funct3_i)
            F3_B:    ext_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    ext_o = {{16{half_s[15]}}, half_s};
            F3_BU:   ext_o = {24'h000000, byte_s};
            F3_HU:   ext_o = {16'h0000, half_s};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// OSIRIS I MEM-stage load/store unit: accepts one access at a time, drives the
// req/ack data-memory port, stalls the pipeline while outstanding and times out.
module load_store_unit
    import osiris_lsu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid_MEM,
    input  logic             i_flush_MEM,
    input  logic             i_mem_read_MEM,
    input  logic             i_mem_write_MEM,
    input  logic [2:0]       i_funct3_MEM,
    input  logic [WIDTH-1:0] i_addr_MEM,
    input  logic [WIDTH-1:0] i_wdata_MEM,
    output logic             o_stall_MEM,
    output logic [WIDTH-1:0] o_rdata_MEM,
    output logic             o_rdata_valid_MEM,
    output logic             o_misaligned_MEM,
    output logic             o_bus_error_MEM,
    load_store_unit_if.master dmem
);

    localparam int CNT_W = TIMEOUT_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             cand_s;
    logic             ok_s;
    logic             stall_s;
    logic             misaligned_s;
    logic [WIDTH-1:0] load_ext_s;

    assign cand_s = i_valid_MEM & ~i_flush_MEM & (i_mem_read_MEM | i_mem_write_MEM);
    assign ok_s   = (i_mem_read_MEM ^ i_mem_write_MEM)
                  & f3_legal(i_mem_write_MEM, i_funct3_MEM)
                  & f3_aligned(i_funct3_MEM, i_addr_MEM[1:0]);

    lsu_load_align u_align (
        .rdata_i  (dmem.i_dmem_rdata),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .ext_o    (load_ext_s)
    );

    // Next-state, acceptance, timeout and combinational handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rdata_d      = rdata_q;
        stall_s      = 1'b0;
        misaligned_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_s && ok_s) begin
                    addr_d   = {i_addr_MEM[WIDTH-1:2], 2'b00};
                    be_d     = store_be(i_funct3_MEM, i_addr_MEM[1:0]);
                    wdata_d  = store_wdata(i_funct3_MEM, i_wdata_MEM);
                    we_d     = i_mem_write_MEM;
                    funct3_d = i_funct3_MEM;
                    off_d    = i_addr_MEM[1:0];
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    stall_s  = 1'b1;
                    state_d  = BUSY;
                end else if (cand_s) begin
                    misaligned_s = 1'b1;
                end else begin
                    misaligned_s = 1'b0;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem.i_dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = load_ext_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State and access registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_stall_MEM       = stall_s;
    assign o_misaligned_MEM  = misaligned_s;
    assign o_rdata_MEM       = rdata_q;
    assign o_rdata_valid_MEM = (state_q == DONE) & ~we_q & ~err_q;
    assign o_bus_error_MEM   = (state_q == DONE) & err_q;

    assign dmem.o_dmem_req   = (state_q == BUSY);
    assign dmem.o_dmem_we    = we_q;
    assign dmem.o_dmem_addr  = addr_q;
    assign dmem.o_dmem_be    = be_q;
    assign dmem.o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected per-access results are queued
// when an access is issued and compared when the unit reaches DONE.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        valid, flush, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic        stall, rvalid, mis, berr;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_rdata = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        rvalid;
        logic        berr;
        int          reqs;
    } sb_t;

    sb_t sb_q[$];

    load_store_unit_if #(.WIDTH(32)) dmem_if ();

    load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_valid_MEM       (valid),
        .i_flush_MEM       (flush),
        .i_mem_read_MEM    (rd),
        .i_mem_write_MEM   (wr),
        .i_funct3_MEM      (f3),
        .i_addr_MEM        (addr),
        .i_wdata_MEM       (wd),
        .o_stall_MEM       (stall),
        .o_rdata_MEM       (rdata),
        .o_rdata_valid_MEM (rvalid),
        .o_misaligned_MEM  (mis),
        .o_bus_error_MEM   (berr),
        .dmem              (dmem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (fn)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    // ack_at: BUSY cycle (1-based) on which ack is given; 0 = never.
    task automatic run_access(input string tag, input logic is_wr, input logic [2:0] fn,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] mem_word, input int ack_at);
        sb_t e, got_e;
        int reqs, stalls;
        bit done;
        reqs = 0; stalls = 0; done = 0;
        e.addr  = {a[31:2], 2'b00};
        e.we    = is_wr;
        e.berr  = (ack_at == 0) || (ack_at > 16);
        e.reqs  = e.berr ? 16 : ack_at;
        case (fn[1:0])
            2'b00:   begin e.be = 4'b0001 << a[1:0]; e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
            2'b01:   begin e.be = 4'b0011 << a[1:0]; e.wdata = {d[15:0], d[15:0]}; end
            default: begin e.be = 4'b1111; e.wdata = d; end
        endcase
        if (e.berr)      e.rdata = 32'h0;
        else if (!is_wr) e.rdata = model_load(fn, a[1:0], mem_word);
        else             e.rdata = last_rdata;
        e.rvalid = !is_wr && !e.berr;
        last_rdata = e.rdata;
        sb_q.push_back(e);

        @(negedge clk);
        valid = 1'b1; rd = ~is_wr; wr = is_wr; f3 = fn; addr = a; wd = d;
        #1;
        check_eq({tag, "_accept_stall"}, {31'h0, stall}, 32'h1);
        check_eq({tag, "_accept_mis"}, {31'h0, mis}, 32'h0);
        stalls = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            idle_inputs();
            dmem_if.i_dmem_ack = 1'b0;
            #1;
            if (dmem_if.o_dmem_req) begin
                reqs++;
                if (stall) stalls++;
                if (reqs == 1) begin
                    check_eq({tag, "_addr"}, dmem_if.o_dmem_addr, e.addr);
                    check_eq({tag, "_be"}, {28'h0, dmem_if.o_dmem_be}, {28'h0, e.be});
                    check_eq({tag, "_we"}, {31'h0, dmem_if.o_dmem_we}, {31'h0, e.we});
                    if (is_wr) check_eq({tag, "_wdata"}, dmem_if.o_dmem_wdata, e.wdata);
                end
                dmem_if.i_dmem_ack   = (reqs == ack_at);
                dmem_if.i_dmem_rdata = mem_word;
            end else begin
                done = 1;
                got_e = sb_q.pop_front();
                check_eq({tag, "_reqs"}, reqs, got_e.reqs);
                check_eq({tag, "_stall_cycles"}, stalls, got_e.reqs + 1);
                check_eq({tag, "_done_stall"}, {31'h0, stall}, 32'h0);
                check_eq({tag, "_rdata"}, rdata, got_e.rdata);
                check_eq({tag, "_rvalid"}, {31'h0, rvalid}, {31'h0, got_e.rvalid});
                check_eq({tag, "_berr"}, {31'h0, berr}, {31'h0, got_e.berr});
            end
        end
        if (!done) check_eq({tag, "_no_done_bound"}, 32'h0, 32'h1);
        dmem_if.i_dmem_ack = 1'b0;
    endtask

    task automatic run_reject(input string tag, input logic r, input logic w, input logic fl,
                              input logic [2:0] fn, input logic [31:0] a, input logic exp_mis);
        @(negedge clk);
        valid = 1'b1; flush = fl; rd = r; wr = w; f3 = fn; addr = a; wd = 32'h1234_5678;
        dmem_if.i_dmem_ack = 1'b1;
        #1;
        check_eq({tag, "_mis"}, {31'h0, mis}, {31'h0, exp_mis});
        check_eq({tag, "_stall"}, {31'h0, stall}, 32'h0);
        @(negedge clk);
        #1;
        check_eq({tag, "_req_next"}, {31'h0, dmem_if.o_dmem_req}, 32'h0);
        idle_inputs();
        dmem_if.i_dmem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        f3 = 3'b000; addr = 32'h0; wd = 32'h0;
        dmem_if.i_dmem_ack = 1'b0;
        dmem_if.i_dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", {31'h0, dmem_if.o_dmem_req}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_flags", {28'h0, stall, rvalid, berr, mis}, 32'h0);
        rst_n = 1'b1;

        run_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        run_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1);
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1);
        run_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 3);
        run_access("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF7F01, 1);
        run_access("sb",  1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1);
        run_access("sh",  1'b1, 3'b001, 32'h302, 32'h0000CAFE, 32'h0, 2);
        run_access("sw",  1'b1, 3'b010, 32'h404, 32'h11223344, 32'h0, 1);

        run_reject("lh_mis",  1'b1, 1'b0, 1'b0, 3'b001, 32'h101, 1'b1);
        run_reject("lw_mis",  1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 1'b1);
        run_reject("sbu_ill", 1'b0, 1'b1, 1'b0, 3'b100, 32'h200, 1'b1);
        run_reject("rw_ill",  1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 1'b1);
        run_reject("flush",   1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 1'b0);

        run_access("tmo",      1'b0, 3'b010, 32'h500, 32'h0, 32'h55AA55AA, 0);
        run_access("tmo_ack",  1'b0, 3'b010, 32'h504, 32'h0, 32'h0BADF00D, 16);

        // Reset while BUSY: request must drop at the reset edge.
        @(negedge clk);
        valid = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_eq("midrst_busy_req", {31'h0, dmem_if.o_dmem_req}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_req", {31'h0, dmem_if.o_dmem_req}, 32'h0);
        check_eq("midrst_rdata", rdata, 32'h0);
        check_eq("midrst_flags", {29'h0, stall, rvalid, berr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 32'h0;
        run_access("post_rst_lw", 1'b0, 3'b010, 32'h700, 32'h0, 32'hA5A5_0F0F, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage load/store unit of the OSIRIS I pipeline.
- Consumes the EX-stage ALU result as the effective address, together with the forwarded rs2 store data and the decoded memory controls.
- Drives a req/ack data-memory port with byte enables, returns sign/zero-extended load data to writeback, and stalls the pipeline while an access is outstanding.
- Bounds every access with a timeout that raises a bus error.

Parameters:
- WIDTH, 32, datapath and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY waiting for i_dmem_ack before a bus error is raised.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid_MEM  input  1  a valid instruction occupies MEM.
- i_flush_MEM  input  1  squash the MEM instruction; effective only in IDLE.
- i_mem_read_MEM  input  1  instruction is a load.
- i_mem_write_MEM  input  1  instruction is a store.
- i_funct3_MEM  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr_MEM  input  WIDTH  effective address (ALU result).
- i_wdata_MEM  input  WIDTH  store data (rs2).
- o_stall_MEM  output  1  hold IF..MEM stages.
- o_rdata_MEM  output  WIDTH  extended load data.
- o_rdata_valid_MEM  output  1  one-cycle completion pulse for loads.
- o_misaligned_MEM  output  1  misaligned or illegal-size access rejected.
- o_bus_error_MEM  output  1  access timed out.
- o_dmem_req  output  1  memory request.
- o_dmem_we  output  1  1 = write.
- o_dmem_addr  output  WIDTH  word-aligned address, with {addr[WIDTH-1:2], 2'b00}.
- o_dmem_be  output  4  byte enables.
- o_dmem_wdata  output  WIDTH  lane-replicated store data.
- i_dmem_ack  input  1  memory completes the request this cycle.
- i_dmem_rdata  input  WIDTH  read word; valid when i_dmem_ack is high.

Behaviour:
- Reset (i_rst_n low at an edge):
  - state = IDLE, timeout counter = 0.
  - o_rdata_MEM = 0.
  - All registered outputs = 0.
  - o_dmem_req falls at that same edge, including mid-transaction; memory must tolerate an abandoned request.
- FSM states: IDLE, BUSY, DONE.
- IDLE, acceptance:
  - Accept when i_valid_MEM & ~i_flush_MEM & (read | write) & legal & aligned.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Aligned: H requires addr[0]=0; W requires addr[1:0]=0.
  - On accept: register word address, be, wdata, we, funct3 and byte offset; set o_stall_MEM=1 combinationally; next state BUSY.
- IDLE, rejection:
  - If the acceptance conditions hold except legal & aligned, assert o_misaligned_MEM combinationally for that cycle.
  - No request, no stall, stay IDLE.
  - read & write both set is illegal and is rejected the same way.
- BUSY:
  - o_dmem_req=1; addr/we/be/wdata are held stable from registers; o_stall_MEM=1; the counter increments each cycle.
  - On i_dmem_ack: capture extended load data (loads only; stores leave o_rdata_MEM unchanged) and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: set the error flag, set o_rdata_MEM=0, and go to DONE.
  - Ack arriving on the timeout cycle wins over the timeout.
- DONE:
  - o_stall_MEM=0 and o_dmem_req=0.
  - o_rdata_valid_MEM=1 for loads without error.
  - o_bus_error_MEM=1 if the error flag is set.
  - Next state IDLE; clear counter and flag.
  - The instruction still in MEM this cycle is not re-issued because the pipeline advances on this edge.
- Latency: minimum 3 cycles (accept, BUSY with ack, DONE); stall is high for (1 + BUSY cycles).
- i_dmem_ack outside BUSY is ignored.
- i_flush_MEM in BUSY/DONE is ignored; an issued store is never cancelled.
- Store formatting:
  - SB: wdata = {4{byte}}, be = 0001 << off.
  - SH: wdata = {2{half}}, be = 0011 << off.
  - SW: wdata = word, be = 1111.
- Load extraction:
  - Select byte/half by the registered offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.

Decomposition:
- Package osiris_lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - the width of the TIMEOUT counter ($clog2(TIMEOUT_CYCLES)).
- One combinational sub-module, lsu_load_align: inputs are rdata, offset and funct3; output is the extended word.
- FSM, store formatting and counter stay in load_store_unit.

Test Plan:
- LW at addr 0x100 with ack after 2 BUSY cycles and rdata 0xDEADBEEF:
  - o_dmem_addr=0x100, be=1111, we=0.
  - Stall high for 3 cycles.
  - DONE shows o_rdata_MEM=0xDEADBEEF, rdata_valid=1.
- Sub-word loads with rdata 0x80FF7F01:
  - LB at 0x103 -> 0xFFFFFF80.
  - LBU at 0x103 -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
  - LHU at 0x100 -> 0x00007F01.
- SB of 0x000000AB at 0x201:
  - be=0010, wdata=0xABABABAB, addr=0x200, we=1.
  - No rdata_valid pulse in DONE.
- LH at 0x101 and LW at 0x102:
  - o_misaligned_MEM=1 in the same cycle, o_dmem_req never rises, no stall.
- Timeout: LW with ack held low:
  - Req high for exactly 16 cycles, then o_bus_error_MEM=1, o_rdata_MEM=0, stall drops.
  - Repeat with ack on the 16th BUSY cycle -> normal completion, no error.
- Reset mid-BUSY (i_rst_n low for 1 cycle):
  - Req drops at that edge; state IDLE; outputs zero.
  - Next valid load is accepted normally.
  - Flush in the acceptance cycle -> no request.
